// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller:
// sequencer states, EX forwarding selects and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipe_sequencer_if.sv
// ID-stage hazard inputs and pipeline control strobes exchanged between the
// datapath (master) and the sequencer (slave).
interface pipe_sequencer_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             mem_br_taken;
  logic             halt_req;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regwrite, id_memread,
           mem_br_taken, halt_req,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, fwd_a, fwd_b,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regwrite, id_memread,
           mem_br_taken, halt_req,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, fwd_a, fwd_b,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous
// active-high clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Hazard and sequencing controller for a 5-stage pipe: load-use stalls,
// taken-branch flushes, EX forwarding selects and drain/halt sequencing.
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_sequencer_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
  } stage_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             mr;
  } ex_stage_t;

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);

  state_e    state_q, state_d;
  logic      id_v_q, id_v_d;
  ex_stage_t ex_q, ex_d;
  stage_t    mem_q, mem_d;
  stage_t    wb_q, wb_d;

  logic       lu, br, pipe_empty;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, halted;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input stage_t mem, input stage_t wb);
    if (mem.v && mem.rw && (mem.rd != ZERO_REG) && (mem.rd == src)) return FWD_MEM;
    if (wb.v && wb.rw && (wb.rd != ZERO_REG) && (wb.rd == src))     return FWD_WB;
    return FWD_REG;
  endfunction

  assign lu = ex_q.v && ex_q.mr && (ex_q.rd != ZERO_REG) && id_v_q &&
              ((bus.id_uses_rs && (ex_q.rd == bus.id_rs)) ||
               (bus.id_uses_rt && (ex_q.rd == bus.id_rt)));
  assign br = bus.mem_br_taken && mem_q.v;
  assign pipe_empty = !(id_v_q || ex_q.v || mem_q.v || wb_q.v);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    fwd_a       = fwd_sel(ex_q.rs, mem_q, wb_q);
    fwd_b       = fwd_sel(ex_q.rt, mem_q, wb_q);

    case (state_q)
      ST_RUN: begin
        if (bus.halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        pc_we      = 1'b0;
        ifid_flush = 1'b1;
        if (!bus.halt_req) state_d = ST_RUN;
        else if (pipe_empty) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        halted  = 1'b1;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        if (!bus.halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // A taken branch wins over a load-use stall; the stalled ID op is wrong-path anyway.
    if (br) begin
      pc_we       = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end

    if (rst) begin
      state_d     = ST_RUN;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      halted      = 1'b0;
      fwd_a       = FWD_REG;
      fwd_b       = FWD_REG;
    end
  end

  // Invalid slots carry all-zero fields so a bubble can never match a forward.
  always_comb begin
    ex_d = '0;
    if (id_v_q && !idex_bubble) begin
      ex_d.v  = 1'b1;
      ex_d.rd = bus.id_rd;
      ex_d.rw = bus.id_regwrite;
      ex_d.rs = bus.id_rs;
      ex_d.rt = bus.id_rt;
      ex_d.mr = bus.id_memread;
    end

    mem_d = '0;
    if (!exmem_flush) begin
      mem_d.v  = ex_q.v;
      mem_d.rd = ex_q.rd;
      mem_d.rw = ex_q.rw;
    end

    wb_d = mem_q;

    id_v_d = id_v_q;
    if (ifid_flush)   id_v_d = 1'b0;
    else if (ifid_we) id_v_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      id_v_q  <= 1'b0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      id_v_q  <= id_v_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lu && !br),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (br),
    .cnt (bus.flush_cnt)
  );

  assign bus.pc_we       = pc_we;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_flush = exmem_flush;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed scoreboard bench for pipe_sequencer: each cycle's hand-derived
// expected strobes are queued by the stimulus and checked by a monitor.
module tb_pipe_sequencer;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       ut;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_sequencer_if #(.REG_W(5), .CNT_W(16)) bus ();

  pipe_sequencer #(.REG_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  function automatic instr_t i_nop();
    return '0;
  endfunction
  function automatic instr_t i_alu(int rd, int rs, int rt);
    return '{rs: 5'(rs), rt: 5'(rt), ur: 1'b1, ut: 1'b1, rd: 5'(rd), rw: 1'b1, mr: 1'b0};
  endfunction
  function automatic instr_t i_lw(int rt, int rs);
    return '{rs: 5'(rs), rt: 5'(rt), ur: 1'b1, ut: 1'b0, rd: 5'(rt), rw: 1'b1, mr: 1'b1};
  endfunction
  function automatic instr_t i_beq(int rs, int rt);
    return '{rs: 5'(rs), rt: 5'(rt), ur: 1'b1, ut: 1'b1, rd: 5'd0, rw: 1'b0, mr: 1'b0};
  endfunction

  function automatic exp_t mk(logic pc, logic we, logic fl, logic bub, logic exf,
                              logic [1:0] fa, logic [1:0] fb, logic h,
                              logic [15:0] s, logic [15:0] f);
    return '{pc_we: pc, ifid_we: we, ifid_flush: fl, idex_bubble: bub, exmem_flush: exf,
             fwd_a: fa, fwd_b: fb, halted: h, stall_cnt: s, flush_cnt: f};
  endfunction
  function automatic exp_t e_run(logic [1:0] fa, logic [1:0] fb, logic [15:0] s, logic [15:0] f);
    return mk(1, 1, 0, 0, 0, fa, fb, 0, s, f);
  endfunction
  function automatic exp_t e_stall(logic [1:0] fa, logic [1:0] fb, logic [15:0] s, logic [15:0] f);
    return mk(0, 0, 0, 1, 0, fa, fb, 0, s, f);
  endfunction
  function automatic exp_t e_flush(logic [1:0] fa, logic [1:0] fb, logic [15:0] s, logic [15:0] f);
    return mk(1, 1, 1, 1, 1, fa, fb, 0, s, f);
  endfunction
  function automatic exp_t e_drain(logic [1:0] fa, logic [1:0] fb, logic [15:0] s, logic [15:0] f);
    return mk(0, 1, 1, 0, 0, fa, fb, 0, s, f);
  endfunction
  function automatic exp_t e_halt(logic [15:0] s, logic [15:0] f);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, s, f);
  endfunction
  function automatic exp_t e_rst(logic [15:0] s, logic [15:0] f);
    return mk(0, 0, 1, 1, 1, 2'b00, 2'b00, 0, s, f);
  endfunction

  // One cycle of stimulus: drive just after the edge, queue what the cycle must show.
  task automatic cyc(input string nm, input logic r, input instr_t in, input logic br,
                     input logic hq, input logic chk, input exp_t e);
    @(posedge clk);
    #1;
    rst              = r;
    bus.id_rs        = in.rs;
    bus.id_rt        = in.rt;
    bus.id_uses_rs   = in.ur;
    bus.id_uses_rt   = in.ut;
    bus.id_rd        = in.rd;
    bus.id_regwrite  = in.rw;
    bus.id_memread   = in.mr;
    bus.mem_br_taken = br;
    bus.halt_req     = hq;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      a  = '{pc_we: bus.pc_we, ifid_we: bus.ifid_we, ifid_flush: bus.ifid_flush,
             idex_bubble: bus.idex_bubble, exmem_flush: bus.exmem_flush,
             fwd_a: bus.fwd_a, fwd_b: bus.fwd_b, halted: bus.halted,
             stall_cnt: bus.stall_cnt, flush_cnt: bus.flush_cnt};
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s: got pc=%b ifwe=%b ifl=%b bub=%b exf=%b fa=%b fb=%b h=%b sc=%h fc=%h, want pc=%b ifwe=%b ifl=%b bub=%b exf=%b fa=%b fb=%b h=%b sc=%h fc=%h",
                 nm, a.pc_we, a.ifid_we, a.ifid_flush, a.idex_bubble, a.exmem_flush,
                 a.fwd_a, a.fwd_b, a.halted, a.stall_cnt, a.flush_cnt,
                 e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble, e.exmem_flush,
                 e.fwd_a, e.fwd_b, e.halted, e.stall_cnt, e.flush_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_rd = '0; bus.id_regwrite = 1'b0; bus.id_memread = 1'b0;
    bus.mem_br_taken = 1'b0; bus.halt_req = 1'b0;

    cyc("rst_init",  1, i_nop(), 0, 0, 0, e_rst(0, 0));
    cyc("rst_state", 1, i_nop(), 0, 0, 1, e_rst(0, 0));

    // Load-use: lw $2 then add $3,$2,$4
    cyc("fetch_lw",   0, i_nop(),        0, 0, 1, e_run(2'b00, 2'b00, 0, 0));
    cyc("lw_in_id",   0, i_lw(2, 1),     0, 0, 1, e_run(2'b00, 2'b00, 0, 0));
    cyc("lu_stall",   0, i_alu(3, 2, 4), 0, 0, 1, e_stall(2'b00, 2'b00, 0, 0));
    cyc("lu_release", 0, i_alu(3, 2, 4), 0, 0, 1, e_run(2'b00, 2'b00, 1, 0));
    cyc("lu_fwd_wb",  0, i_alu(5, 1, 1), 0, 0, 1, e_run(2'b01, 2'b00, 1, 0));

    // ALU->ALU dependency and writes to $0
    cyc("sub_in_id",  0, i_alu(6, 5, 5), 0, 0, 1, e_run(2'b00, 2'b00, 1, 0));
    cyc("fwd_mem_ab", 0, i_alu(0, 3, 3), 0, 0, 1, e_run(2'b10, 2'b10, 1, 0));
    cyc("no_match",   0, i_alu(7, 0, 0), 0, 0, 1, e_run(2'b00, 2'b00, 1, 0));
    cyc("zero_dst",   0, i_nop(),        0, 0, 1, e_run(2'b00, 2'b00, 1, 0));

    // Taken branch reaching MEM
    cyc("beq_in_id",  0, i_beq(8, 9),       0, 0, 1, e_run(2'b00, 2'b00, 1, 0));
    cyc("shadow_1",   0, i_alu(10, 11, 12), 0, 0, 1, e_run(2'b00, 2'b00, 1, 0));
    cyc("br_flush",   0, i_alu(13, 10, 10), 1, 0, 1, e_flush(2'b00, 2'b00, 1, 0));
    cyc("post_flush", 0, i_nop(),           0, 0, 1, e_run(2'b00, 2'b00, 1, 1));

    // Load-use and taken branch in the same cycle
    cyc("beq2_in_id", 0, i_beq(8, 9),    0, 0, 1, e_run(2'b00, 2'b00, 1, 1));
    cyc("lw2_in_id",  0, i_lw(2, 1),     0, 0, 1, e_run(2'b00, 2'b00, 1, 1));
    cyc("lu_and_br",  0, i_alu(3, 2, 4), 1, 0, 1, e_flush(2'b00, 2'b00, 1, 1));
    cyc("post_both",  0, i_nop(),        0, 0, 1, e_run(2'b00, 2'b00, 1, 2));

    // Drain and halt with the pipe full
    cyc("fill_14",    0, i_alu(14, 1, 1), 0, 0, 1, e_run(2'b00, 2'b00, 1, 2));
    cyc("fill_15",    0, i_alu(15, 1, 1), 0, 0, 1, e_run(2'b00, 2'b00, 1, 2));
    cyc("fill_16",    0, i_alu(16, 1, 1), 0, 0, 1, e_run(2'b00, 2'b00, 1, 2));
    cyc("halt_req",   0, i_alu(17, 1, 1), 0, 1, 1, e_run(2'b00, 2'b00, 1, 2));
    cyc("drain_0",    0, i_alu(18, 1, 1), 0, 1, 1, e_drain(2'b00, 2'b00, 1, 2));
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("drain_%0d", i), 0, i_nop(), 0, 1, 1, e_drain(2'b00, 2'b00, 1, 2));
    cyc("halted",     0, i_nop(), 0, 1, 1, e_halt(1, 2));
    cyc("halt_drop",  0, i_nop(), 0, 0, 1, e_halt(1, 2));
    cyc("resume",     0, i_nop(), 0, 0, 1, e_run(2'b00, 2'b00, 1, 2));

    // Saturation of the stall counter, then reset while draining
    cyc("sat_preset", 0, i_lw(2, 1), 0, 0, 1, e_run(2'b00, 2'b00, 16'hFFFF, 2));
    force dut.u_stall_cnt.cnt_q = 16'hFFFF;
    cyc("sat_lu",     0, i_alu(3, 2, 4), 0, 0, 1, e_stall(2'b00, 2'b00, 16'hFFFF, 2));
    release dut.u_stall_cnt.cnt_q;
    cyc("sat_hold",   0, i_alu(3, 2, 4), 0, 0, 1, e_run(2'b00, 2'b00, 16'hFFFF, 2));
    cyc("sat_fwd_wb", 0, i_nop(),        0, 1, 1, e_run(2'b01, 2'b00, 16'hFFFF, 2));
    cyc("rst_drain",  1, i_nop(),        0, 1, 1, e_rst(16'hFFFF, 2));
    cyc("post_rst",   0, i_nop(),        0, 1, 1, e_run(2'b00, 2'b00, 0, 0));
    cyc("drain_drop", 0, i_nop(),        0, 0, 1, e_drain(2'b00, 2'b00, 0, 0));
    cyc("rerun",      0, i_nop(),        0, 0, 1, e_run(2'b00, 2'b00, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain_queue: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
